// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS controller:
// FSM state encoding, opcode/funct fields, ALU op classes and ALU codes.
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEXEC = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11
   } statetype_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in,
// every mux select, enable and ALU control out. master = controller side.
interface mc_controller_if;

   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pcen;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic       alusrca;
   logic       iord;
   logic       memtoreg;
   logic       regdst;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [2:0] alucontrol;

   modport master (
      input  op, funct, zero,
      output pcen, memwrite, irwrite, regwrite,
      output alusrca, iord, memtoreg, regdst,
      output alusrcb, pcsrc, alucontrol
   );

   modport slave (
      output op, funct, zero,
      input  pcen, memwrite, irwrite, regwrite,
      input  alusrca, iord, memtoreg, regdst,
      input  alusrcb, pcsrc, alucontrol
   );

endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: maps aluop class and funct to the 3-bit ALU control.
// Ports: aluop (2), funct (6) in; alucontrol (3) out.
import mc_pkg::*;

module mc_aludec (
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         default: begin
            // aluop 1x: R-type, funct selects the operation
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM plus ALU decoder.
// Ports: clk, reset (async high), bus (master), state (debug).
import mc_pkg::*;

module mc_controller #(
   parameter int NSTATEBITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   mc_controller_if.master       bus,
   output logic [NSTATEBITS-1:0] state
);

   statetype_t cur;
   statetype_t nxt;
   logic       pcwrite;
   logic       branch;
   logic [1:0] aluop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur <= FETCH;
      else       cur <= nxt;
   end

   assign state = NSTATEBITS'(cur);

   always_comb begin
      nxt = FETCH;
      case (cur)
         FETCH: nxt = DECODE;
         DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: nxt = MEMADR;
               OP_RTYPE:     nxt = EXECUTE;
               OP_BEQ:       nxt = BRANCH;
               OP_ADDI:      nxt = ADDIEXEC;
               OP_J:         nxt = JUMP;
               default:      nxt = FETCH;
            endcase
         end
         MEMADR:   nxt = (bus.op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:    nxt = MEMWB;
         EXECUTE:  nxt = ALUWB;
         ADDIEXEC: nxt = ADDIWB;
         default:  nxt = FETCH;
      endcase
   end

   always_comb begin
      pcwrite      = 1'b0;
      branch       = 1'b0;
      aluop        = ALUOP_ADD;
      bus.memwrite = 1'b0;
      bus.irwrite  = 1'b0;
      bus.regwrite = 1'b0;
      bus.alusrca  = 1'b0;
      bus.iord     = 1'b0;
      bus.memtoreg = 1'b0;
      bus.regdst   = 1'b0;
      bus.alusrcb  = 2'b00;
      bus.pcsrc    = 2'b00;
      case (cur)
         FETCH: begin
            bus.irwrite = 1'b1;
            pcwrite     = 1'b1;
            bus.alusrcb = 2'b01;
         end
         DECODE: begin
            // precompute branch target PC+4+(imm<<2)
            bus.alusrcb = 2'b11;
         end
         MEMADR, ADDIEXEC: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
         end
         MEMRD: bus.iord = 1'b1;
         MEMWB: begin
            bus.memtoreg = 1'b1;
            bus.regwrite = 1'b1;
         end
         MEMWR: begin
            bus.iord     = 1'b1;
            bus.memwrite = 1'b1;
         end
         EXECUTE: begin
            bus.alusrca = 1'b1;
            aluop       = ALUOP_FUNCT;
         end
         ALUWB: begin
            bus.regdst   = 1'b1;
            bus.regwrite = 1'b1;
         end
         BRANCH: begin
            bus.alusrca = 1'b1;
            aluop       = ALUOP_SUB;
            bus.pcsrc   = 2'b01;
            branch      = 1'b1;
         end
         ADDIWB: bus.regwrite = 1'b1;
         JUMP: begin
            bus.pcsrc = 2'b10;
            pcwrite   = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.pcen = pcwrite | (branch & bus.zero);

   mc_aludec u_aludec (
      .aluop      (aluop),
      .funct      (bus.funct),
      .alucontrol (bus.alucontrol)
   );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed and random
// instruction streams against a per-instruction reference model.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] state;
   int         n_chk = 0;
   int         n_pass = 0;

   mc_controller_if bus ();

   mc_controller #(.NSTATEBITS(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .state (state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pcw;
      logic       br;
      logic       mw;
      logic       irw;
      logic       rw;
      logic       asa;
      logic       iord;
      logic       m2r;
      logic       rdst;
      logic [1:0] asb;
      logic [1:0] psrc;
      logic [1:0] aop;
   } row_t;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                    tag, got, exp, $time);
   endtask

   // signals asserted in each state, straight from the state table
   function automatic row_t spec_row(int s);
      row_t r;
      r = '0;
      case (s)
         0:  begin r.irw = 1; r.pcw = 1; r.asb = 2'b01; end
         1:  r.asb = 2'b11;
         2:  begin r.asa = 1; r.asb = 2'b10; end
         3:  r.iord = 1;
         4:  begin r.m2r = 1; r.rw = 1; end
         5:  begin r.iord = 1; r.mw = 1; end
         6:  begin r.asa = 1; r.aop = 2'b10; end
         7:  begin r.rdst = 1; r.rw = 1; end
         8:  begin r.asa = 1; r.aop = 2'b01; r.psrc = 2'b01; r.br = 1; end
         9:  begin r.asa = 1; r.asb = 2'b10; end
         10: r.rw = 1;
         11: begin r.psrc = 2'b10; r.pcw = 1; end
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [2:0] alu_ref(logic [1:0] aop, logic [5:0] f);
      if (aop == 2'b00) return 3'b010;
      if (aop == 2'b01) return 3'b110;
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic void state_seq(logic [5:0] op, ref int q[$]);
      q = {0, 1};
      case (op)
         6'b100011: q = {q, 2, 3, 4};
         6'b101011: q = {q, 2, 5};
         6'b000000: q = {q, 6, 7};
         6'b001000: q = {q, 9, 10};
         6'b000100: q.push_back(8);
         6'b000010: q.push_back(11);
         default: ;
      endcase
   endfunction

   task automatic check_outputs(int s, string tag);
      row_t       r;
      logic [11:0] got;
      logic [11:0] exp;
      logic        pcen_e;
      r = spec_row(s);
      pcen_e = r.pcw | (r.br & bus.zero);
      exp = {pcen_e, r.mw, r.irw, r.rw, r.asa, r.iord,
             r.m2r, r.rdst, r.asb, r.psrc};
      got = {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite,
             bus.alusrca, bus.iord, bus.memtoreg, bus.regdst,
             bus.alusrcb, bus.pcsrc};
      chk({tag, "_state"}, state, s);
      chk({tag, "_ctrl"}, got, exp);
      chk({tag, "_alu"}, bus.alucontrol, alu_ref(r.aop, bus.funct));
      chk({tag, "_wexcl"},
          32'(bus.memwrite + bus.regwrite + bus.irwrite <= 2'd1), 1);
   endtask

   // Runs one instruction from FETCH. zmode: 0/1 force zero, 2 random.
   // abort_at >= 0 asserts reset mid-instruction at that cycle.
   task automatic run_instr(logic [5:0] op, logic [5:0] fn,
                            int zmode, int abort_at, string tag);
      int q[$];
      state_seq(op, q);
      bus.op = op;
      bus.funct = fn;
      for (int k = 0; k < q.size(); k++) begin
         bus.zero = (zmode == 2) ? 1'($urandom_range(0, 1))
                                 : 1'(zmode);
         @(negedge clk);
         check_outputs(q[k], tag);
         if (k == abort_at) begin
            #2 reset = 1'b1;
            #1;
            chk({tag, "_async_rst"}, state, 0);
            check_outputs(0, {tag, "_rst_held"});
            @(posedge clk);
            #1 reset = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [5:0] ops [6];
      logic [5:0] fns [5];
      logic [5:0] op;
      logic [5:0] fn;
      ops = '{6'b100011, 6'b101011, 6'b000000,
              6'b000100, 6'b001000, 6'b000010};
      fns = '{6'b100000, 6'b100010, 6'b100100,
              6'b100101, 6'b101010};
      bus.op = 6'b0;
      bus.funct = 6'b0;
      bus.zero = 1'b0;
      #1;
      chk("rst_state", state, 0);
      @(negedge clk);
      check_outputs(0, "rst_hold");
      @(posedge clk);
      #1 reset = 1'b0;

      run_instr(6'b100011, 6'b0, 2, -1, "lw");
      run_instr(6'b000000, 6'b101010, 2, -1, "slt");
      run_instr(6'b000100, 6'b0, 1, -1, "beq_z1");
      run_instr(6'b000100, 6'b0, 0, -1, "beq_z0");
      run_instr(6'b101011, 6'b0, 2, -1, "sw");
      run_instr(6'b000010, 6'b0, 2, -1, "j");
      run_instr(6'b111111, 6'b0, 2, -1, "unk");
      run_instr(6'b001000, 6'b0, 2, -1, "addi");
      run_instr(6'b100011, 6'b0, 2, 3, "lw_abort");
      run_instr(6'b000000, 6'b100010, 2, -1, "sub_after_rst");

      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 7))
            6: op = 6'($urandom);
            7: op = 6'b000000;
            default: op = ops[$urandom_range(0, 5)];
         endcase
         if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
         else fn = fns[$urandom_range(0, 4)];
         run_instr(op, fn, 2,
                   ($urandom_range(0, 19) == 0) ? 2 : -1, "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Control unit for the multicycle MIPS processor; sits directly upstream of the multicycle datapath.
- Consumes op, funct and zero from the datapath.
- Produces every datapath mux select, write enable and ALU control, plus the memory write enable.
- Moore main FSM with a combinational ALU decoder.

Parameters:
- NSTATEBITS, 4, width of the state register and the debug state output.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; forces FETCH
- op  input  6  instr[31:26] from the datapath
- funct  input  6  instr[5:0] from the datapath
- zero  input  1  ALU zero flag, same cycle
- pcen  output  1  PC register enable
- memwrite  output  1  memory write enable
- irwrite  output  1  instruction register write enable
- regwrite  output  1  register file write enable
- alusrca  output  1  0 = PC, 1 = register A
- iord  output  1  0 = PC address, 1 = ALUOut address
- memtoreg  output  1  0 = ALUOut, 1 = data register
- regdst  output  1  0 = rt, 1 = rd
- alusrcb  output  2  00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- alucontrol  output  3  ALU operation select
- state  output  NSTATEBITS  current FSM state, for debug and verification

Behaviour:
- State register updates on posedge clk. Reset is asynchronous to FETCH (encoding 0); reset mid-instruction abandons that instruction.
- All outputs are combinational decodes of the current state (plus funct and zero); there are no registered outputs.
- While reset is held, outputs equal the FETCH decode.
- Any signal not listed for a state is 0, with alusrcb=00 and pcsrc=00.
- pcen = pcwrite | (branch & zero).

State encoding, signals asserted, and next state:
- FETCH (0): irwrite=1, pcwrite=1, alusrcb=01, aluop=00 -> DECODE.
- DECODE (1): alusrcb=11, aluop=00. Next state by op:
  - lw 100011 or sw 101011 -> MEMADR
  - R-type 000000 -> EXECUTE
  - beq 000100 -> BRANCH
  - addi 001000 -> ADDIEXEC
  - j 000010 -> JUMP
  - any other op -> FETCH (executed as a nop, no write)
- MEMADR (2): alusrca=1, alusrcb=10, aluop=00 -> MEMRD if op=lw, else MEMWR.
- MEMRD (3): iord=1 -> MEMWB.
- MEMWB (4): memtoreg=1, regwrite=1 -> FETCH.
- MEMWR (5): iord=1, memwrite=1 -> FETCH.
- EXECUTE (6): alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
- ALUWB (7): regdst=1, regwrite=1 -> FETCH.
- BRANCH (8): alusrca=1, aluop=01, pcsrc=01, branch=1 -> FETCH.
- ADDIEXEC (9): alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- ADDIWB (10): regwrite=1 -> FETCH.
- JUMP (11): pcsrc=10, pcwrite=1 -> FETCH.
- Unused encodings 12-15 -> FETCH with all enables 0.

Cycles per instruction:
- lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; unknown op 2.

ALU decoder:
- aluop 00 -> 010 (add).
- aluop 01 -> 110 (sub).
- aluop 1x decodes funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - any other funct -> 010

Rules:
- The write enables memwrite, regwrite and irwrite are never asserted in the same state as each other.
- A beq with zero=0 gives pcen=0; the PC holds.

Decomposition:
- Shared package mc_pkg holds:
  - typedef enum statetype_t (12 states, 4-bit encoding as above)
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - aluop constants
- One sub-module, mc_aludec (aluop, funct -> alucontrol).
- The FSM and output decode stay in mc_controller.

Test Plan:
- Reset asserted mid-MEMRD -> state=0 immediately (asynchronous), without waiting for a clock edge; after release, irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- op=100011 (lw) -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; 5 cycles total.
- op=000000, funct=101010 (slt) -> states 0,1,6,7,0; alucontrol=111 in state 6; regdst=1, regwrite=1 in state 7.
- op=000100 (beq): zero=1 in BRANCH -> pcen=1, pcsrc=01, alucontrol=110; repeat with zero=0 -> pcen=0.
- op=101011 (sw) -> memwrite=1, iord=1 in state 5 only; regwrite=0 throughout; op=000010 (j) -> state 11 with pcen=1, pcsrc=10.
- op=111111 (unknown) -> DECODE returns to FETCH; no regwrite or memwrite for the whole instruction; 2 cycles.
